// File: rtl/a2_bridge_pkg.sv
// Shared definitions for the A2 bridge responder.
// Holds the register-select codes, control-register bit positions, the write FSM
// state type and the packed bundle of synchronized Apple-side pins.
package a2_bridge_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CTRL_W = 6;
  localparam int unsigned DIP_W  = 4;

  localparam logic [SEL_W-1:0] SEL_CTRL    = 3'd0;
  localparam logic [SEL_W-1:0] SEL_DATA    = 3'd1;
  localparam logic [SEL_W-1:0] SEL_ADDR_LO = 3'd2;
  localparam logic [SEL_W-1:0] SEL_ADDR_HI = 3'd3;
  localparam logic [SEL_W-1:0] SEL_M2      = 3'd4;
  localparam logic [SEL_W-1:0] SEL_DIP     = 3'd5;

  // Bit positions inside the control register / sel-0 read value
  localparam int unsigned CB_RW    = 0;
  localparam int unsigned CB_INH   = 1;
  localparam int unsigned CB_IRQ   = 2;
  localparam int unsigned CB_RDY   = 3;
  localparam int unsigned CB_DMA   = 4;
  localparam int unsigned CB_NMI   = 5;
  localparam int unsigned CB_RESET = 6;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_ARMED = 1'b1
  } wr_state_e;

  // Apple-side pins as one synchronizer payload
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw_n;
    logic              m2sel_n;
    logic              m2b0;
    logic [CTRL_W-1:0] ctrl_n;
    logic [DIP_W-1:0]  dip_n;
  } a2_pins_t;

  // Active-low lines come out of reset deasserted
  localparam a2_pins_t PINS_RST = '{
    addr:    16'h0000,
    data:    8'h00,
    rw_n:    1'b1,
    m2sel_n: 1'b1,
    m2b0:    1'b0,
    ctrl_n:  6'h3F,
    dip_n:   4'hF
  };

endpackage

// File: rtl/a2_sync.sv
// Multi-stage synchronizer with a configurable reset value.
// Ports: clk, rst (sync, active-high), d (async input bus), q (synchronized bus).
module a2_sync #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       STAGES  = 2,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/a2_bridge_responder.sv
// Bridge-side responder for the A2N20v2 Apple II bus bridge.
// Synchronizes Apple slot pins, snapshots the address group for multi-byte reads,
// serves register reads combinationally and commits master writes.
// Ports: clk_logic_i/system_reset_i (sync active-high); bridge_* master port
// (sel, rd_n, wr_n, write data + oe, read data + oe, Apple bus drive request);
// a2_* Apple pins in; dip_switches_n_i; a2_data_o/oe, a2_ctrl_oe_o drive;
// wr_strobe_o / wr_err_o single-cycle write status.
module a2_bridge_responder
  import a2_bridge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FREEZE_TIMEOUT = 15,
  parameter logic [5:0]  CTRL_OUT_MASK  = 6'b000010
) (
  input  logic        clk_logic_i,
  input  logic        system_reset_i,
  input  logic [2:0]  bridge_sel_i,
  input  logic        bridge_rd_n_i,
  input  logic        bridge_wr_n_i,
  input  logic [7:0]  bridge_d_i,
  input  logic        bridge_d_oe_i,
  output logic [7:0]  bridge_d_o,
  output logic        bridge_d_oe_o,
  input  logic        bridge_bus_d_oe_n_i,
  input  logic [15:0] a2_addr_i,
  input  logic [7:0]  a2_data_i,
  input  logic        a2_rw_n_i,
  input  logic        a2_m2sel_n_i,
  input  logic        a2_m2b0_i,
  input  logic [5:0]  a2_ctrl_n_i,
  input  logic [3:0]  dip_switches_n_i,
  output logic [7:0]  a2_data_o,
  output logic        a2_data_oe_o,
  output logic [5:0]  a2_ctrl_oe_o,
  output logic        wr_strobe_o,
  output logic        wr_err_o
);

  localparam int unsigned CNT_W = $clog2(FREEZE_TIMEOUT + 1);

  // Input synchronization
  a2_pins_t pins_raw;
  a2_pins_t live;

  assign pins_raw = {a2_addr_i, a2_data_i, a2_rw_n_i, a2_m2sel_n_i, a2_m2b0_i,
                     a2_ctrl_n_i, dip_switches_n_i};

  a2_sync #(
    .WIDTH   ($bits(a2_pins_t)),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (PINS_RST)
  ) u_sync (
    .clk (clk_logic_i),
    .rst (system_reset_i),
    .d   (pins_raw),
    .q   (live)
  );

  // Address-group snapshot and freeze control
  logic [ADDR_W-1:0] snap_addr;
  logic              snap_rw_n;
  logic              snap_m2sel_n;
  logic              snap_m2b0;
  logic              frozen;
  logic [CNT_W-1:0]  freeze_cnt;
  logic [CNT_W-1:0]  freeze_cnt_inc;
  logic [SEL_W-1:0]  prev_sel;
  logic              freeze_set;
  logic              freeze_rel;

  assign freeze_cnt_inc = freeze_cnt + CNT_W'(1);
  assign freeze_set = (bridge_sel_i == SEL_ADDR_LO) && !bridge_rd_n_i &&
                      (prev_sel != SEL_ADDR_LO);
  assign freeze_rel = frozen &&
                      (((prev_sel == SEL_M2) && (bridge_sel_i != SEL_M2)) ||
                       bridge_rd_n_i ||
                       (freeze_cnt_inc == CNT_W'(FREEZE_TIMEOUT)));

  // The release cycle also reloads the snapshot so the next read sequence sees fresh pins
  always_ff @(posedge clk_logic_i) begin
    if (system_reset_i) begin
      frozen       <= 1'b0;
      freeze_cnt   <= '0;
      prev_sel     <= '0;
      snap_addr    <= PINS_RST.addr;
      snap_rw_n    <= PINS_RST.rw_n;
      snap_m2sel_n <= PINS_RST.m2sel_n;
      snap_m2b0    <= PINS_RST.m2b0;
    end else begin
      prev_sel <= bridge_sel_i;
      if (freeze_set) begin
        frozen     <= 1'b1;
        freeze_cnt <= '0;
      end else if (freeze_rel) begin
        frozen     <= 1'b0;
        freeze_cnt <= '0;
      end else if (frozen) begin
        freeze_cnt <= freeze_cnt_inc;
      end
      if ((!frozen || freeze_rel) && !freeze_set) begin
        snap_addr    <= live.addr;
        snap_rw_n    <= live.rw_n;
        snap_m2sel_n <= live.m2sel_n;
        snap_m2b0    <= live.m2b0;
      end
    end
  end

  // Zero-latency register read mux
  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'hFF;
    if (!bridge_rd_n_i) begin
      case (bridge_sel_i)
        SEL_CTRL:    rd_data = {1'b1, live.ctrl_n, snap_rw_n};
        SEL_DATA:    rd_data = live.data;
        SEL_ADDR_LO: rd_data = snap_addr[7:0];
        SEL_ADDR_HI: rd_data = snap_addr[15:8];
        SEL_M2:      rd_data = {6'h3F, snap_m2sel_n, snap_m2b0};
        SEL_DIP:     rd_data = {4'hF, live.dip_n};
        default:     rd_data = 8'hFF;
      endcase
    end
  end

  assign bridge_d_o    = rd_data;
  assign bridge_d_oe_o = !bridge_rd_n_i && bridge_wr_n_i && !bridge_d_oe_i;
  assign a2_data_oe_o  = !bridge_bus_d_oe_n_i && live.rw_n;

  // Write FSM
  wr_state_e        wr_state;
  wr_state_e        wr_state_next;
  logic [SEL_W-1:0] cap_sel;
  logic [SEL_W-1:0] cap_sel_next;
  logic [7:0]       cap_d;
  logic [7:0]       cap_d_next;
  logic             wr_bad;
  logic             wr_bad_next;
  logic             commit_ctrl;
  logic             commit_data;
  logic             strobe_next;
  logic             err_next;

  always_ff @(posedge clk_logic_i) begin
    if (system_reset_i) wr_state <= WR_IDLE;
    else                wr_state <= wr_state_next;
  end

  always_comb begin
    wr_state_next = wr_state;
    cap_sel_next  = cap_sel;
    cap_d_next    = cap_d;
    wr_bad_next   = wr_bad;
    commit_ctrl   = 1'b0;
    commit_data   = 1'b0;
    strobe_next   = 1'b0;
    err_next      = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (!bridge_wr_n_i) begin
          wr_state_next = WR_ARMED;
          cap_sel_next  = bridge_sel_i;
          cap_d_next    = bridge_d_i;
          wr_bad_next   = !bridge_d_oe_i;
        end
      end
      WR_ARMED: begin
        if (!bridge_wr_n_i) begin
          if ((bridge_sel_i != cap_sel) || !bridge_d_oe_i) wr_bad_next = 1'b1;
        end else begin
          // wr_n may rise together with a sel change, so decode the captured sel
          wr_state_next = WR_IDLE;
          if (wr_bad) begin
            err_next = 1'b1;
          end else if (cap_sel == SEL_CTRL) begin
            commit_ctrl = 1'b1;
            strobe_next = 1'b1;
          end else if (cap_sel == SEL_DATA) begin
            commit_data = 1'b1;
            strobe_next = 1'b1;
          end
        end
      end
      default: wr_state_next = WR_IDLE;
    endcase
  end

  // Commit targets; the control register is kept as its open-drain enable image
  always_ff @(posedge clk_logic_i) begin
    if (system_reset_i) begin
      cap_sel      <= '0;
      cap_d        <= '0;
      wr_bad       <= 1'b0;
      a2_data_o    <= 8'h00;
      a2_ctrl_oe_o <= '0;
      wr_strobe_o  <= 1'b0;
      wr_err_o     <= 1'b0;
    end else begin
      cap_sel     <= cap_sel_next;
      cap_d       <= cap_d_next;
      wr_bad      <= wr_bad_next;
      wr_strobe_o <= strobe_next;
      wr_err_o    <= err_next;
      if (commit_data) a2_data_o <= cap_d;
      if (commit_ctrl) a2_ctrl_oe_o <= ~cap_d[CB_RESET:CB_INH] & CTRL_OUT_MASK;
    end
  end

endmodule

// File: tb/tb_a2_bridge_responder.sv
// Self-checking bench for a2_bridge_responder: directed stimulus, a cycle model
// of the register map / snapshot / write rules, and hand-computed spot checks.
module tb_a2_bridge_responder;
  import a2_bridge_pkg::*;

  localparam int unsigned SYNC    = 2;
  localparam int unsigned TIMEOUT = 15;
  localparam logic [5:0]  MASK    = 6'b000010;

  logic        clk = 1'b0;
  logic        system_reset;
  logic [2:0]  sel;
  logic        rd_n, wr_n, d_oe, bus_d_oe_n;
  logic [7:0]  d;
  logic [15:0] addr;
  logic [7:0]  adata;
  logic        rw_n, m2sel_n, m2b0;
  logic [5:0]  ctrl_n;
  logic [3:0]  dip_n;
  logic [7:0]  bridge_d_o;
  logic        bridge_d_oe_o;
  logic [7:0]  a2_data_o;
  logic        a2_data_oe_o;
  logic [5:0]  a2_ctrl_oe_o;
  logic        wr_strobe_o, wr_err_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  a2_bridge_responder #(
    .SYNC_STAGES(SYNC), .FREEZE_TIMEOUT(TIMEOUT), .CTRL_OUT_MASK(MASK)
  ) dut (
    .clk_logic_i(clk), .system_reset_i(system_reset),
    .bridge_sel_i(sel), .bridge_rd_n_i(rd_n), .bridge_wr_n_i(wr_n),
    .bridge_d_i(d), .bridge_d_oe_i(d_oe), .bridge_d_o(bridge_d_o),
    .bridge_d_oe_o(bridge_d_oe_o), .bridge_bus_d_oe_n_i(bus_d_oe_n),
    .a2_addr_i(addr), .a2_data_i(adata), .a2_rw_n_i(rw_n),
    .a2_m2sel_n_i(m2sel_n), .a2_m2b0_i(m2b0), .a2_ctrl_n_i(ctrl_n),
    .dip_switches_n_i(dip_n), .a2_data_o(a2_data_o), .a2_data_oe_o(a2_data_oe_o),
    .a2_ctrl_oe_o(a2_ctrl_oe_o), .wr_strobe_o(wr_strobe_o), .wr_err_o(wr_err_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  a2_pins_t   pins_now;
  a2_pins_t   m_hist [SYNC];
  a2_pins_t   m_snap;
  a2_pins_t   m_live;
  logic [2:0] m_prev_sel;
  logic       m_frozen;
  int         m_frozen_cycles;
  logic       m_armed, m_bad;
  logic [2:0] m_cap_sel;
  logic [7:0] m_cap_d, m_data, m_ctrl;
  logic       m_strobe, m_err, m_valid = 1'b0;
  logic       m_set, m_rel, m_wr_end;

  assign pins_now = {addr, adata, rw_n, m2sel_n, m2b0, ctrl_n, dip_n};
  assign m_live   = m_hist[SYNC-1];
  assign m_set    = (sel == 3'd2) && !rd_n && (m_prev_sel != 3'd2);
  assign m_rel    = m_frozen && (((m_prev_sel == 3'd4) && (sel != 3'd4)) || rd_n ||
                                 (m_frozen_cycles + 1 == int'(TIMEOUT)));
  assign m_wr_end = m_armed && wr_n;

  always @(posedge clk) begin
    if (system_reset) begin
      for (int i = 0; i < int'(SYNC); i++) m_hist[i] <= PINS_RST;
      m_snap <= PINS_RST; m_prev_sel <= 3'd0; m_frozen <= 1'b0; m_frozen_cycles <= 0;
      m_armed <= 1'b0; m_bad <= 1'b0; m_cap_sel <= 3'd0; m_cap_d <= 8'h00;
      m_data <= 8'h00; m_ctrl <= 8'hFF; m_strobe <= 1'b0; m_err <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      m_hist[0] <= pins_now;
      for (int i = 1; i < int'(SYNC); i++) m_hist[i] <= m_hist[i-1];
      m_prev_sel <= sel;
      if (m_set) begin
        m_frozen <= 1'b1; m_frozen_cycles <= 0;
      end else if (m_rel) begin
        m_frozen <= 1'b0; m_frozen_cycles <= 0;
      end else if (m_frozen) begin
        m_frozen_cycles <= m_frozen_cycles + 1;
      end
      if ((!m_frozen || m_rel) && !m_set) m_snap <= m_live;
      m_strobe <= m_wr_end && !m_bad && (m_cap_sel == 3'd0 || m_cap_sel == 3'd1);
      m_err    <= m_wr_end && m_bad;
      if (!m_armed && !wr_n) begin
        m_armed <= 1'b1; m_cap_sel <= sel; m_cap_d <= d; m_bad <= !d_oe;
      end else if (m_armed && !wr_n) begin
        m_bad <= m_bad || (sel != m_cap_sel) || !d_oe;
      end else if (m_wr_end) begin
        m_armed <= 1'b0;
        if (!m_bad && m_cap_sel == 3'd0) m_ctrl <= m_cap_d;
        if (!m_bad && m_cap_sel == 3'd1) m_data <= m_cap_d;
      end
    end
  end

  // Compare process: every output, every cycle once the model is initialised
  initial begin
    logic [7:0] rmap [8];
    logic [7:0] exp_rd;
    logic [5:0] exp_oe;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        rmap[0] = {1'b1, m_live.ctrl_n, m_snap.rw_n};
        rmap[1] = m_live.data;
        rmap[2] = m_snap.addr[7:0];
        rmap[3] = m_snap.addr[15:8];
        rmap[4] = {6'b111111, m_snap.m2sel_n, m_snap.m2b0};
        rmap[5] = {4'b1111, m_live.dip_n};
        rmap[6] = 8'hFF;
        rmap[7] = 8'hFF;
        exp_rd = rd_n ? 8'hFF : rmap[sel];
        for (int i = 0; i < 6; i++) exp_oe[i] = !m_ctrl[i+1] && MASK[i];
        chk("model_rd_data", 32'(bridge_d_o), 32'(exp_rd));
        chk("model_rd_oe", 32'(bridge_d_oe_o), 32'(!rd_n && wr_n && !d_oe));
        chk("model_a2_data", 32'(a2_data_o), 32'(m_data));
        chk("model_a2_data_oe", 32'(a2_data_oe_o), 32'(!bus_d_oe_n && m_live.rw_n));
        chk("model_ctrl_oe", 32'(a2_ctrl_oe_o), 32'(exp_oe));
        chk("model_strobe", 32'(wr_strobe_o), 32'(m_strobe));
        chk("model_err", 32'(wr_err_o), 32'(m_err));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [2:0] s, input logic [7:0] v);
    sel = s; d = v; d_oe = 1'b1; wr_n = 1'b0;
    tick();
    wr_n = 1'b1;
    tick();
    d_oe = 1'b0; sel = 3'd7;
  endtask

  initial begin
    logic [7:0] rd_log [20];
    #80000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd_log [20];
    system_reset = 1'b1; sel = 3'd7; rd_n = 1'b1; wr_n = 1'b1; d = 8'h00; d_oe = 1'b0;
    bus_d_oe_n = 1'b1; addr = 16'h0000; adata = 8'h00; rw_n = 1'b1; m2sel_n = 1'b1;
    m2b0 = 1'b0; ctrl_n = 6'h3F; dip_n = 4'hF;
    tick(3);
    chk("rst_a2_data", 32'(a2_data_o), 32'h00);
    chk("rst_ctrl_oe", 32'(a2_ctrl_oe_o), 32'h0);
    chk("rst_pulses", 32'({wr_strobe_o, wr_err_o}), 32'h0);
    chk("rst_rd_idle", 32'(bridge_d_o), 32'hFF);
    system_reset = 1'b0;
    tick();

    // DIP read and unmapped select
    dip_n = 4'b0110;
    tick(3);
    sel = 3'd5; rd_n = 1'b0; #2;
    chk("dip_read", 32'(bridge_d_o), 32'hF6);
    chk("dip_read_oe", 32'(bridge_d_oe_o), 32'h1);
    sel = 3'd7; #2;
    chk("sel7_read", 32'(bridge_d_o), 32'hFF);
    tick();
    rd_n = 1'b1;
    tick();

    // Address snapshot across a 2,3,0,4 read sequence
    addr = 16'hC0F1; rw_n = 1'b0;
    tick(4);
    sel = 3'd2; rd_n = 1'b0; #2;
    chk("snap_lo", 32'(bridge_d_o), 32'hF1);
    tick();
    addr = 16'h1234; sel = 3'd3; #2;
    chk("snap_hi", 32'(bridge_d_o), 32'hC0);
    tick();
    sel = 3'd0; #2;
    chk("snap_rw_bit", 32'(bridge_d_o[0]), 32'h0);
    chk("snap_ctrl_byte", 32'(bridge_d_o), 32'hFE);
    tick();
    sel = 3'd4; #2;
    chk("snap_m2", 32'(bridge_d_o), 32'hFE);
    tick();
    sel = 3'd0;
    tick();
    sel = 3'd2; #2;
    chk("snap_after_release", 32'(bridge_d_o), 32'h34);
    tick();
    rd_n = 1'b1; sel = 3'd7;
    tick();

    // Data write with wr_n rising alongside a sel change
    sel = 3'd1; d = 8'hA5; d_oe = 1'b1; wr_n = 1'b0;
    tick();
    wr_n = 1'b1; sel = 3'd0;
    tick(); #2;
    chk("data_latch", 32'(a2_data_o), 32'hA5);
    chk("data_strobe", 32'(wr_strobe_o), 32'h1);
    d_oe = 1'b0; sel = 3'd7;
    tick(); #2;
    chk("data_strobe_single", 32'(wr_strobe_o), 32'h0);

    // Apple data drive enable follows live rw_n
    bus_d_oe_n = 1'b0; rw_n = 1'b1;
    tick(3);
    chk("a2_oe_read_cycle", 32'(a2_data_oe_o), 32'h1);
    rw_n = 1'b0;
    tick(3);
    chk("a2_oe_write_cycle", 32'(a2_data_oe_o), 32'h0);
    bus_d_oe_n = 1'b1;

    // Control register writes through the output mask
    do_write(3'd0, 8'hFB); #2;
    chk("ctrl_irq_drive", 32'(a2_ctrl_oe_o), 32'h02);
    tick();
    do_write(3'd0, 8'hF7); #2;
    chk("ctrl_rdy_masked", 32'(a2_ctrl_oe_o), 32'h00);
    tick();

    // Aborted write: sel moves while wr_n is low
    sel = 3'd1; d = 8'h3C; d_oe = 1'b1; wr_n = 1'b0;
    tick();
    sel = 3'd2;
    tick();
    wr_n = 1'b1;
    tick(); #2;
    chk("abort_err", 32'(wr_err_o), 32'h1);
    chk("abort_no_strobe", 32'(wr_strobe_o), 32'h0);
    chk("abort_latch_kept", 32'(a2_data_o), 32'hA5);
    d_oe = 1'b0; sel = 3'd7;
    tick(); #2;
    chk("abort_err_single", 32'(wr_err_o), 32'h0);

    // Freeze timeout while sel 2 is held with rd_n low
    addr = 16'h5A01; rw_n = 1'b1;
    tick(4);
    sel = 3'd2; rd_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) addr = 16'h5A99;
      #2;
      rd_log[i] = bridge_d_o;
      tick();
    end
    chk("freeze_first", 32'(rd_log[0]), 32'h01);
    chk("freeze_held", 32'(rd_log[15]), 32'h01);
    chk("freeze_released", 32'(rd_log[16]), 32'h99);
    chk("freeze_tracks", 32'(rd_log[19]), 32'h99);
    rd_n = 1'b1; sel = 3'd7;
    tick();

    // Reset while a write is armed
    sel = 3'd1; d = 8'h77; d_oe = 1'b1; wr_n = 1'b0;
    tick();
    system_reset = 1'b1; wr_n = 1'b1;
    tick(2);
    system_reset = 1'b0; d_oe = 1'b0; sel = 3'd7;
    tick(); #2;
    chk("rst_armed_latch", 32'(a2_data_o), 32'h00);
    chk("rst_armed_ctrl", 32'(a2_ctrl_oe_o), 32'h0);
    chk("rst_armed_pulses", 32'({wr_strobe_o, wr_err_o}), 32'h0);
    tick(); #2;
    chk("rst_armed_no_late_pulse", 32'({wr_strobe_o, wr_err_o}), 32'h0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
